gamepad_reader: RTL and testbench

Upstream stage of button_controller: polls PAD_COUNT serial shift-register gamepads (NES-style latch/clock/data) and presents a stable parallel button vector on buttons_out, which drives button_controller.buttons_in.
- A poll is started once per frame by poll_start (same frame strobe that precedes copy_start).
- buttons_out updates atomically at end of poll, so the DMA copy never sees a half-read vector.

---
 rtl/gamepad_pkg.sv | 15 +
 rtl/constants.svh | 6 +
 rtl/pad_shift_rx.sv | 62 ++++++
 rtl/gamepad_reader.sv | 132 +++++++++++++
 tb/tb_gamepad_reader.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/gamepad_pkg.sv
// Shared FSM state type and timing constants for the gamepad poller.
package gamepad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_HIGH,
        CLK_LOW,
        DONE
    } state_t;

    // Latch pulse width, in half-phases of the pad clock.
    localparam int LATCH_HALF_PHASES = 2;

endpackage

// File: rtl/constants.svh
// Project-wide key constants shared by the input path.
`ifndef GAMEPAD_CONSTANTS_SVH
`define GAMEPAD_CONSTANTS_SVH
`define KEY_NUM       16
`define KEY_NUM_WIDTH 4
`endif

// File: rtl/pad_shift_rx.sv
// Per-pad receiver: 2-flop synchroniser, serial-to-parallel shift register, committed button byte.
// Latency: sample-to-commit set by the parent FSM; buttons update the cycle after commit.
// Backpressure: none; strobes come from the parent FSM. Debounce via GAMEPAD_DEBOUNCE_EN.
module pad_shift_rx
    import gamepad_pkg::*;
#(
    parameter int BUTTONS_PER_PAD = 8,
    parameter int IDX_W           = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pad_data,
    input  logic                       sample,
    input  logic [IDX_W-1:0]           index,
    input  logic                       commit,
    output logic [BUTTONS_PER_PAD-1:0] buttons
);

    logic [1:0]                 sync;
    logic [BUTTONS_PER_PAD-1:0] shift;
    logic [BUTTONS_PER_PAD-1:0] fresh;

    // Pad lines are active-low; unplugged pads float high and read released.
    assign fresh = ~shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            shift <= '0;
        end else begin
            sync <= {sync[0], pad_data};
            if (sample)
                shift[index] <= sync[1];
        end
    end

`ifdef GAMEPAD_DEBOUNCE_EN
    logic [BUTTONS_PER_PAD-1:0] prev;
    logic [BUTTONS_PER_PAD-1:0] agree;

    assign agree = ~(fresh ^ prev);

    // A bit moves only once two consecutive polls report the same value.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= '0;
            buttons <= '0;
        end else if (commit) begin
            prev    <= fresh;
            buttons <= (buttons & ~agree) | (fresh & agree);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset)
            buttons <= '0;
        else if (commit)
            buttons <= fresh;
    end
`endif

endmodule

// File: rtl/gamepad_reader.sv
// Polls PAD_COUNT NES-style serial pads once per poll_start and publishes buttons_out atomically.
// Latency: 2*CLK_DIV*(BUTTONS_PER_PAD+1)+2 cycles from poll_start to poll_done/buttons_out.
// Backpressure: poll_start is dropped while busy or in DONE. Optional GAMEPAD_DEBOUNCE_EN.
`include "constants.svh"

module gamepad_reader
    import gamepad_pkg::*;
#(
    parameter int PAD_COUNT       = 2,
    parameter int BUTTONS_PER_PAD = 8,
    parameter int BUTTON_COUNT    = `KEY_NUM,
    parameter int CLK_DIV         = 4,
    parameter int DIV_WIDTH       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    poll_start,
    input  logic [PAD_COUNT-1:0]    pad_data,
    output logic                    pad_latch,
    output logic                    pad_clk,
    output logic [BUTTON_COUNT-1:0] buttons_out,
    output logic                    poll_done,
    output logic                    busy
);

    localparam int                   IDX_W      = $clog2(BUTTONS_PER_PAD);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(BUTTONS_PER_PAD - 1);
    localparam logic [1:0]           LATCH_LAST = 2'(LATCH_HALF_PHASES - 1);

    generate
        if (BUTTON_COUNT != PAD_COUNT * BUTTONS_PER_PAD) begin : g_bad_width
            $error("gamepad_reader: BUTTON_COUNT must equal PAD_COUNT*BUTTONS_PER_PAD");
        end
        if (CLK_DIV < 1 || CLK_DIV > (1 << DIV_WIDTH)) begin : g_bad_div
            $error("gamepad_reader: CLK_DIV out of range for DIV_WIDTH");
        end
    endgenerate

    state_t               state;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [1:0]           latch_half;
    logic [IDX_W-1:0]     bit_idx;
    logic                 div_last;
    logic                 sample;
    logic                 commit;

    assign div_last = (div_cnt == DIV_LAST);
    assign sample   = (state == CLK_HIGH) && div_last;
    assign commit   = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            latch_half <= '0;
            bit_idx    <= '0;
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b1;
            poll_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            poll_done <= 1'b0;
            if (state != IDLE && state != DONE)
                div_cnt <= div_last ? '0 : div_cnt + DIV_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (poll_start) begin
                        state      <= LATCH;
                        div_cnt    <= '0;
                        latch_half <= '0;
                        bit_idx    <= '0;
                        pad_latch  <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        if (latch_half == LATCH_LAST) begin
                            state      <= CLK_HIGH;
                            latch_half <= '0;
                            pad_latch  <= 1'b0;
                        end else begin
                            latch_half <= latch_half + 2'd1;
                        end
                    end
                end
                CLK_HIGH: begin
                    if (div_last) begin
                        state   <= CLK_LOW;
                        pad_clk <= 1'b0;
                    end
                end
                CLK_LOW: begin
                    if (div_last) begin
                        pad_clk <= 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= DONE;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            state   <= CLK_HIGH;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    poll_done <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar p = 0; p < PAD_COUNT; p++) begin : g_pad
            pad_shift_rx #(
                .BUTTONS_PER_PAD(BUTTONS_PER_PAD),
                .IDX_W          (IDX_W)
            ) u_rx (
                .clk     (clk),
                .reset   (reset),
                .pad_data(pad_data[p]),
                .sample  (sample),
                .index   (bit_idx),
                .commit  (commit),
                .buttons (buttons_out[p*BUTTONS_PER_PAD +: BUTTONS_PER_PAD])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader with a behavioural NES pad model on each data line.
module tb_gamepad_reader;

`ifdef GAMEPAD_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        poll_start = 1'b0;
    logic [1:0]  pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [15:0] buttons_out;
    logic        poll_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] pad_val0 = 8'hFF;
    logic [7:0] pad_val1 = 8'hFF;
    logic [7:0] sh0 = 8'hFF;
    logic [7:0] sh1 = 8'hFF;
    logic       pclk_q = 1'b1;
    logic       unplug = 1'b0;

    int done_at, latch_first, latch_last, latch_cnt, low_pulses, extra;

    always #5 clk = ~clk;

    gamepad_reader #(
        .PAD_COUNT      (2),
        .BUTTONS_PER_PAD(8),
        .BUTTON_COUNT   (16),
        .CLK_DIV        (4),
        .DIV_WIDTH      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .poll_start (poll_start),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .buttons_out(buttons_out),
        .poll_done  (poll_done),
        .busy       (busy)
    );

    // Pad model: latch loads the report (bit0 first), each pad_clk rising edge shifts in 1s.
    always @(posedge clk) begin
        if (pad_latch) begin
            sh0 <= pad_val0;
            sh1 <= pad_val1;
        end else if (pad_clk && !pclk_q) begin
            sh0 <= {1'b1, sh0[7:1]};
            sh1 <= {1'b1, sh1[7:1]};
        end
        pclk_q <= pad_clk;
    end

    assign pad_data = unplug ? 2'b11 : {sh1[0], sh0[0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (poll_done === 1'b1) cnt++;
        end
    endtask

    // Cycle 0 is the cycle poll_start is high; returns at the poll_done cycle or after the budget.
    task automatic run_poll(input int inject_at, output int d_at, output int l_first,
                            output int l_last, output int l_cnt, output int lows);
        logic prev_clk;
        d_at = -1; l_first = -1; l_last = -1; l_cnt = 0; lows = 0;
        tick();
        poll_start = 1'b1;
        tick();
        poll_start = 1'b0;
        prev_clk = pad_clk;
        for (int t = 1; t < 200; t++) begin
            poll_start = (t == inject_at);
            if (pad_latch === 1'b1) begin
                if (l_first < 0) l_first = t;
                l_last = t;
                l_cnt++;
            end
            if (prev_clk === 1'b1 && pad_clk === 1'b0) lows++;
            prev_clk = pad_clk;
            if (poll_done === 1'b1) begin
                d_at = t;
                break;
            end
            tick();
        end
        poll_start = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;

        count_dones(100, extra);
        check("idle_done_count", extra, 0);
        check("idle_pad_latch", pad_latch, 1'b0);
        check("idle_pad_clk", pad_clk, 1'b1);
        check("idle_buttons", buttons_out, 16'h0000);
        check("idle_busy", busy, 1'b0);

        // Poll with a second poll_start injected mid-poll, which must be dropped.
        pad_val0 = 8'b1111_1010;
        pad_val1 = 8'hFF;
        run_poll(20, done_at, latch_first, latch_last, latch_cnt, low_pulses);
        check("p1_done_cycle", done_at, 74);
        check("p1_latch_first", latch_first, 1);
        check("p1_latch_last", latch_last, 8);
        check("p1_latch_cycles", latch_cnt, 8);
        check("p1_clk_low_pulses", low_pulses, 8);
        check("p1_buttons", buttons_out, DEB ? 16'h0000 : 16'h0005);
        check("p1_busy_at_done", busy, 1'b0);
        count_dones(100, extra);
        check("p1_no_extra_done", extra, 0);

        run_poll(0, done_at, latch_first, latch_last, latch_cnt, low_pulses);
        check("p2_done_cycle", done_at, 74);
        check("p2_buttons", buttons_out, 16'h0005);

        // Reset in cycle 40 of a poll.
        tick();
        poll_start = 1'b1;
        tick();
        poll_start = 1'b0;
        repeat (39) tick();
        check("rst_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        check("rst_pad_latch", pad_latch, 1'b0);
        check("rst_pad_clk", pad_clk, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_buttons", buttons_out, 16'h0000);
        check("rst_poll_done", poll_done, 1'b0);
        reset = 1'b0;
        count_dones(100, extra);
        check("rst_no_done", extra, 0);

        unplug = 1'b1;
        run_poll(0, done_at, latch_first, latch_last, latch_cnt, low_pulses);
        check("unplug_done_cycle", done_at, 74);
        check("unplug_buttons", buttons_out, 16'h0000);
        unplug = 1'b0;

        // Poll results 1,0,1,1 on pad 0 bit 0.
        pad_val1 = 8'hFF;
        pad_val0 = 8'hFE;
        run_poll(0, done_at, latch_first, latch_last, latch_cnt, low_pulses);
        check("seq1_done_cycle", done_at, 74);
        check("seq1_buttons", buttons_out, DEB ? 16'h0000 : 16'h0001);
        pad_val0 = 8'hFF;
        run_poll(0, done_at, latch_first, latch_last, latch_cnt, low_pulses);
        check("seq2_buttons", buttons_out, 16'h0000);
        pad_val0 = 8'hFE;
        run_poll(0, done_at, latch_first, latch_last, latch_cnt, low_pulses);
        check("seq3_buttons", buttons_out, DEB ? 16'h0000 : 16'h0001);
        run_poll(0, done_at, latch_first, latch_last, latch_cnt, low_pulses);
        check("seq4_done_cycle", done_at, 74);
        check("seq4_buttons", buttons_out, 16'h0001);
        tick();
        check("seq4_done_one_cycle", poll_done, 1'b0);
        check("seq4_hold", buttons_out, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
